// File: rtl/operand_loader_pkg.sv
// Shared types for the calculator operand path: loader FSM states and operation codes.
package calc_pkg;

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_LOAD_OP = 2'd2,
    S_SHOW    = 2'd3
  } load_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/operand_loader_if.sv
// Operand bus between the loader and the calculator: switch inputs in, registered operand set out.
interface operand_loader_if #(
  parameter int WIDTH = 6
);

  logic [WIDTH-1:0] sw;
  logic             sw_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Add_Sub;
  logic             valid;
  logic             calc_strobe;
  logic [1:0]       stage;

  modport master (
    input  sw, sw_op,
    output A, B, Add_Sub, valid, calc_strobe, stage
  );

  modport slave (
    output sw, sw_op,
    input  A, B, Add_Sub, valid, calc_strobe, stage
  );

endinterface

// File: rtl/operand_loader_button_debounce.sv
// Synchronises and debounces an active-low push-button; press_o pulses one cycle per debounced press.
// Latency from first low sample to press_o: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic press_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   level_dly_q;
  logic                   armed_q, armed_d;
  logic                   press_q, press_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Only arm once the chain holds real samples and has seen the key released,
    // so a key held through reset never produces a press.
    armed_d = armed_q | (fill_q[SYNC_STAGES-1] & sync);
    press_d = armed_q & level_dly_q & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      fill_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], button_i};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      armed_q     <= armed_d;
      press_q     <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/operand_loader.sv
// Loads A, B and Add_Sub from the switches over successive debounced presses, then shows the set.
// Outputs update the cycle after a press; calc_strobe pulses once when the set completes.
module operand_loader
  import calc_pkg::*;
#(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button,
  operand_loader_if.master  bus
);

  load_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic             press;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_i (button),
    .press_o  (press)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    if (press) begin
      case (state_q)
        S_LOAD_A: begin
          a_d     = bus.sw;
          state_d = S_LOAD_B;
        end
        S_LOAD_B: begin
          b_d     = bus.sw;
          state_d = S_LOAD_OP;
        end
        S_LOAD_OP: begin
          op_d     = bus.sw_op;
          valid_d  = 1'b1;
          strobe_d = 1'b1;
          state_d  = S_SHOW;
        end
        S_SHOW: begin
          // Operands are kept so the display shows the last set until overwritten.
          valid_d = 1'b0;
          state_d = S_LOAD_A;
        end
        default: begin
          valid_d = 1'b0;
          state_d = S_LOAD_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.Add_Sub     = op_q;
  assign bus.valid       = valid_q;
  assign bus.calc_strobe = strobe_q;
  assign bus.stage       = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with short debounce; completed operand sets are scoreboarded on calc_strobe.
module tb_operand_loader;
  import calc_pkg::*;

  localparam int W  = 6;
  localparam int DC = 4;
  localparam int SS = 2;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic button = 1'b1;

  int checks     = 0;
  int failures   = 0;
  int press_cnt  = 0;
  int strobe_cnt = 0;
  exp_t exp_q[$];

  operand_loader_if #(.WIDTH(W)) ifc ();

  operand_loader #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every calc_strobe must match the next queued operand set.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (u_dut.u_deb.press_o) press_cnt++;
      if (ifc.calc_strobe) begin
        strobe_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL strobe_unexpected: calc_strobe=1 but no operand set expected");
        end else begin
          e = exp_q.pop_front();
          if ({ifc.A, ifc.B, ifc.Add_Sub} !== e || ifc.valid !== 1'b1 || ifc.stage !== 2'd3) begin
            failures++;
            $display("FAIL strobe_set: got A=%b B=%b op=%b valid=%b stage=%0d, want A=%b B=%b op=%b valid=1 stage=3",
                     ifc.A, ifc.B, ifc.Add_Sub, ifc.valid, ifc.stage, e.a, e.b, e.op);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_press(input int hold, input int rel);
    button = 1'b0;
    step(hold);
    button = 1'b1;
    step(rel);
  endtask

  task automatic test_reset();
    int p0;
    rst_n      = 1'b0;
    button     = 1'b0;
    ifc.sw     = '1;
    ifc.sw_op  = 1'b1;
    step(5);
    checks++;
    if ({ifc.A, ifc.B, ifc.Add_Sub, ifc.valid, ifc.calc_strobe, ifc.stage} !== '0) begin
      failures++;
      $display("FAIL reset_in: A=%b B=%b op=%b valid=%b strobe=%b stage=%0d, want all 0",
               ifc.A, ifc.B, ifc.Add_Sub, ifc.valid, ifc.calc_strobe, ifc.stage);
    end
    p0    = press_cnt;
    rst_n = 1'b1;
    step(40);
    checks++;
    if (press_cnt !== p0) begin
      failures++;
      $display("FAIL reset_held_press: presses=%0d want %0d", press_cnt, p0);
    end
    checks++;
    if ({ifc.A, ifc.B, ifc.Add_Sub, ifc.valid, ifc.calc_strobe, ifc.stage} !== '0) begin
      failures++;
      $display("FAIL reset_held_out: A=%b B=%b valid=%b stage=%0d, want all 0",
               ifc.A, ifc.B, ifc.valid, ifc.stage);
    end
    button = 1'b1;
    step(20);
    checks++;
    if (press_cnt !== p0 || ifc.stage !== 2'd0) begin
      failures++;
      $display("FAIL reset_release_event: presses=%0d stage=%0d want %0d and 0", press_cnt, ifc.stage, p0);
    end
  endtask

  task automatic test_full_entry();
    int s0;
    ifc.sw = 6'b000101;
    do_press(12, 12);
    checks++;
    if (ifc.stage !== 2'd1 || ifc.A !== 6'b000101 || ifc.valid !== 1'b0) begin
      failures++;
      $display("FAIL entry_a: stage=%0d A=%b valid=%b want 1 000101 0", ifc.stage, ifc.A, ifc.valid);
    end
    ifc.sw = 6'b111101;
    do_press(12, 12);
    checks++;
    if (ifc.stage !== 2'd2 || ifc.B !== 6'b111101 || ifc.valid !== 1'b0) begin
      failures++;
      $display("FAIL entry_b: stage=%0d B=%b valid=%b want 2 111101 0", ifc.stage, ifc.B, ifc.valid);
    end
    ifc.sw_op = OP_SUB;
    s0 = strobe_cnt;
    exp_q.push_back(exp_t'{a: 6'b000101, b: 6'b111101, op: OP_SUB});
    do_press(12, 12);
    checks++;
    if (strobe_cnt !== s0 + 1) begin
      failures++;
      $display("FAIL entry_strobe_len: strobe cycles=%0d want 1", strobe_cnt - s0);
    end
    checks++;
    if (ifc.stage !== 2'd3 || ifc.valid !== 1'b1 || ifc.Add_Sub !== 1'b1 || $signed(ifc.B) !== -6'sd3) begin
      failures++;
      $display("FAIL entry_show: stage=%0d valid=%b op=%b B=%0d want 3 1 1 -3",
               ifc.stage, ifc.valid, ifc.Add_Sub, $signed(ifc.B));
    end
  endtask

  task automatic test_show_exit();
    bit found = 1'b0;
    ifc.sw    = 6'b101010;
    ifc.sw_op = OP_ADD;
    button    = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (u_dut.u_deb.press_o) found = 1'b1;
    end
    checks++;
    if (!found || ifc.valid !== 1'b1) begin
      failures++;
      $display("FAIL show_press: press seen=%0d valid=%b want 1 1", found, ifc.valid);
    end
    @(negedge clk);
    checks++;
    if (ifc.valid !== 1'b0 || ifc.stage !== 2'd0 || ifc.A !== 6'b000101 ||
        ifc.B !== 6'b111101 || ifc.Add_Sub !== 1'b1) begin
      failures++;
      $display("FAIL show_exit: valid=%b stage=%0d A=%b B=%b op=%b want 0 0 000101 111101 1",
               ifc.valid, ifc.stage, ifc.A, ifc.B, ifc.Add_Sub);
    end
    step(4);
    button = 1'b1;
    step(12);
  endtask

  task automatic test_clean_press_timing();
    logic [W-1:0] exp_a;
    ifc.sw = 6'b010011;
    button = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (u_dut.u_deb.press_o !== (k == 7)) begin
        failures++;
        $display("FAIL timing_press k=%0d: press=%b want %b", k, u_dut.u_deb.press_o, (k == 7));
      end
      exp_a = (k >= 8) ? 6'b010011 : 6'b000101;
      checks++;
      if (ifc.A !== exp_a) begin
        failures++;
        $display("FAIL timing_a k=%0d: A=%b want %b", k, ifc.A, exp_a);
      end
    end
    step(4);
    button = 1'b1;
    step(12);
    checks++;
    if (ifc.stage !== 2'd1) begin
      failures++;
      $display("FAIL timing_stage: stage=%0d want 1", ifc.stage);
    end
  endtask

  task automatic test_bounce();
    int p0 = press_cnt;
    for (int i = 0; i < 5; i++) begin
      button = 1'b0;
      step(2);
      button = 1'b1;
      step(2);
    end
    step(20);
    checks++;
    if (press_cnt !== p0 || ifc.stage !== 2'd1) begin
      failures++;
      $display("FAIL bounce: presses=%0d stage=%0d want %0d 1", press_cnt, ifc.stage, p0);
    end
  endtask

  task automatic test_held();
    int p0 = press_cnt;
    ifc.sw = 6'b110000;
    button = 1'b0;
    step(100);
    checks++;
    if (press_cnt !== p0 + 1 || ifc.stage !== 2'd2 || ifc.B !== 6'b110000) begin
      failures++;
      $display("FAIL held: presses=%0d stage=%0d B=%b want %0d 2 110000", press_cnt, ifc.stage, ifc.B, p0 + 1);
    end
    button = 1'b1;
    step(20);
    checks++;
    if (press_cnt !== p0 + 1 || ifc.stage !== 2'd2) begin
      failures++;
      $display("FAIL held_release: presses=%0d stage=%0d want %0d 2", press_cnt, ifc.stage, p0 + 1);
    end
    ifc.sw_op = OP_ADD;
    exp_q.push_back(exp_t'{a: 6'b010011, b: 6'b110000, op: OP_ADD});
    do_press(12, 12);
    checks++;
    if (press_cnt !== p0 + 2 || ifc.stage !== 2'd3 || ifc.valid !== 1'b1) begin
      failures++;
      $display("FAIL held_second: presses=%0d stage=%0d valid=%b want %0d 3 1",
               press_cnt, ifc.stage, ifc.valid, p0 + 2);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int s0, p0;
    do_press(12, 12);
    ifc.sw = 6'b000111;
    do_press(12, 12);
    ifc.sw = 6'b001000;
    do_press(12, 12);
    checks++;
    if (ifc.stage !== 2'd2) begin
      failures++;
      $display("FAIL mid_setup: stage=%0d want 2", ifc.stage);
    end
    s0        = strobe_cnt;
    p0        = press_cnt;
    ifc.sw_op = OP_SUB;
    button    = 1'b0;
    step(5);
    checks++;
    if (u_dut.u_deb.cnt_q !== 3'd3) begin
      failures++;
      $display("FAIL mid_count: debounce count=%0d want 3", u_dut.u_deb.cnt_q);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.A, ifc.B, ifc.Add_Sub, ifc.valid, ifc.calc_strobe, ifc.stage} !== '0) begin
      failures++;
      $display("FAIL mid_reset: A=%b B=%b op=%b valid=%b strobe=%b stage=%0d want all 0",
               ifc.A, ifc.B, ifc.Add_Sub, ifc.valid, ifc.calc_strobe, ifc.stage);
    end
    button = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(30);
    checks++;
    if (strobe_cnt !== s0 || press_cnt !== p0 || ifc.stage !== 2'd0 || ifc.valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_after: strobes=%0d presses=%0d stage=%0d valid=%b want %0d %0d 0 0",
               strobe_cnt, press_cnt, ifc.stage, ifc.valid, s0, p0);
    end
  endtask

  initial begin
    test_reset();
    test_full_entry();
    test_show_exit();
    test_clean_press_timing();
    test_bounce();
    test_held();
    test_reset_mid_debounce();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d operand sets never strobed, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
